// File: rtl/br_pkg.sv
// Shared definitions for the execute-stage branch resolve unit: branch funct3
// encodings, 2-bit predictor counter type and the flush vector layout.
package br_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef logic [1:0] ctr2_t;

   localparam ctr2_t SNT = 2'b00;
   localparam ctr2_t WNT = 2'b01;
   localparam ctr2_t WT  = 2'b10;
   localparam ctr2_t ST  = 2'b11;

   localparam int FLUSH_IF_ID  = 0;
   localparam int FLUSH_ID_EX  = 1;
   localparam int FLUSH_EX_MEM = 2;

   function automatic ctr2_t ctr_next(input ctr2_t c, input logic taken);
      if (taken) begin
         return (c == ST) ? ST : c + 2'd1;
      end
      return (c == SNT) ? SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/br_bht.sv
// Direct-mapped table of 2-bit saturating predictors: async read for fetch,
// synchronous update from execute, synchronous reset to weakly not-taken.
module br_bht
   import br_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam int DEPTH = 1 << IDX_W;

   ctr2_t entry_q [DEPTH];

   // Read returns the pre-update value when fetch and execute hit the same entry.
   assign rd_taken = entry_q[rd_idx][1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= WNT;
         end
      end else if (wr_en) begin
         entry_q[wr_idx] <= ctr_next(entry_q[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches and jumps against the fetch prediction, issues a
// one-cycle registered redirect/flush, trains the BHT and counts branches.
module branch_resolve_unit
   import br_pkg::*;
#(
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_stall,
   input  logic             i_ex_valid,
   input  logic             i_ex_is_br,
   input  logic             i_ex_is_jmp,
   input  logic [2:0]       i_ex_funct3,
   input  logic [31:0]      i_ex_pc,
   input  logic [31:0]      i_ex_target,
   input  logic             i_ex_pred_taken,
   input  logic             i_br_eq,
   input  logic             i_br_lt,
   output logic             o_cmp_signed,
   input  logic [31:0]      i_if_pc,
   output logic             o_if_pred_taken,
   output logic             o_redirect,
   output logic [31:0]      o_redirect_pc,
   output logic [2:0]       o_flush,
   output logic [CNT_W-1:0] o_br_count,
   output logic [CNT_W-1:0] o_mispred_count
);

   logic        legal_br;
   logic        cond_taken;
   logic        resolve;
   logic        jmp_res;
   logic        br_res;
   logic        mispred;
   logic        redirect_d;
   logic [2:0]  flush_d;
   logic [31:0] redirect_pc_d;
   logic        unused_if_pc;

   assign o_cmp_signed = ~i_ex_funct3[1];

   always_comb begin
      legal_br   = 1'b1;
      cond_taken = 1'b0;
      case (i_ex_funct3)
         F3_BEQ:           cond_taken = i_br_eq;
         F3_BNE:           cond_taken = ~i_br_eq;
         F3_BLT, F3_BLTU:  cond_taken = i_br_lt;
         F3_BGE, F3_BGEU:  cond_taken = ~i_br_lt;
         default:          legal_br   = 1'b0;
      endcase
   end

   // While a redirect is out, the EX instruction is wrong-path and must not resolve.
   assign resolve    = i_ex_valid & ~i_stall & ~o_redirect;
   assign jmp_res    = resolve & i_ex_is_jmp;
   assign br_res     = resolve & i_ex_is_br & ~i_ex_is_jmp & legal_br;
   assign mispred    = cond_taken != i_ex_pred_taken;
   assign redirect_d = jmp_res | (br_res & mispred);

   assign redirect_pc_d = (i_ex_is_jmp | cond_taken) ? i_ex_target : i_ex_pc + 32'd4;

   always_comb begin
      flush_d               = '0;
      flush_d[FLUSH_IF_ID]  = redirect_d;
      flush_d[FLUSH_ID_EX]  = redirect_d;
      flush_d[FLUSH_EX_MEM] = redirect_d;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_redirect      <= 1'b0;
         o_redirect_pc   <= '0;
         o_flush         <= '0;
         o_br_count      <= '0;
         o_mispred_count <= '0;
      end else begin
         o_redirect <= redirect_d;
         o_flush    <= flush_d;
         if (redirect_d) begin
            o_redirect_pc <= redirect_pc_d;
         end
         if (br_res) begin
            o_br_count <= o_br_count + CNT_W'(1);
            if (mispred) begin
               o_mispred_count <= o_mispred_count + CNT_W'(1);
            end
         end
      end
   end

   br_bht #(
      .IDX_W (IDX_W)
   ) u_bht (
      .clk      (i_clk),
      .reset    (i_reset),
      .rd_idx   (i_if_pc[IDX_W+1:2]),
      .rd_taken (o_if_pred_taken),
      .wr_en    (br_res),
      .wr_idx   (i_ex_pc[IDX_W+1:2]),
      .wr_taken (cond_taken)
   );

   assign unused_if_pc = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

endmodule
